// File: rtl/motion_pkg.sv
// motion_pkg: direction codes, sequencer state encoding and direction decode shared by the sequencer and monitors
package motion_pkg;
  localparam logic [2:0] DIR_B = 3'd0;
  localparam logic [2:0] DIR_R = 3'd1;
  localparam logic [2:0] DIR_S = 3'd2;
  localparam logic [2:0] DIR_L = 3'd3;
  localparam logic [2:0] DIR_F = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;
  function automatic logic [4:0] dir_onehot(input logic [2:0] d);
    return d > DIR_F ? 5'd0 : 5'd1 << d;
  endfunction
endpackage

// File: rtl/motion_sequencer_prescaler.sv
// tick_prescaler: divides clk by PRESCALE while enabled, emitting one tick per wrap
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic I_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(PRESCALE - 1);
  always_ff @(posedge clk or posedge I_rst)
    if (I_rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: plays a stored (direction, duration) program onto set/running with dead-time, pause and abort
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 16,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 4
) (
  input  logic                       clk,
  input  logic                       I_rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [2:0]                 prog_dir,
  input  logic [DUR_W-1:0]           prog_dur,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       abort,
  output logic [4:0]                 set,
  output logic                       running,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(DEAD + 1);
  localparam logic [GW-1:0] G_LAST = GW'(DEAD - 1);
  localparam logic [GW-1:0] G_MID  = GW'(DEAD > 1 ? DEAD - 2 : 0);
  logic [2:0]       dir_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  state_t           state;
  logic [AW-1:0]    idx;
  logic [LW-1:0]    len;
  logic [DUR_W-1:0] cnt;
  logic [GW-1:0]    gap;
  logic [2:0]       cur_dir;
  logic [DUR_W-1:0] cur_dur;
  logic             last, tick;
  assign cur_dir  = dir_mem[idx];
  assign cur_dur  = dur_mem[idx];
  assign last     = ({1'b0, idx} + LW'(1)) == len;
  assign step_idx = idx;
  always_ff @(posedge clk)
    if (prog_we && !busy) begin
      dir_mem[prog_addr] <= prog_dir;
      dur_mem[prog_addr] <= prog_dur;
    end
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .I_rst(I_rst),
    .en   (state == S_RUN && running),
    .clr  (state == S_LOAD),
    .tick (tick)
  );
  // Counting only advances in cycles whose outputs were live, so pause never loses time.
  // Between steps the LOAD cycle is part of the dead-time gap, so GAP is one shorter there.
  always_ff @(posedge clk or posedge I_rst)
    if (I_rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      len     <= '0;
      cnt     <= '0;
      gap     <= '0;
      set     <= '0;
      running <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        idx     <= '0;
        set     <= '0;
        running <= 1'b0;
        busy    <= 1'b0;
      end else case (state)
        S_IDLE: if (start) begin
          if (prog_len == '0) done <= 1'b1;
          else begin
            state <= S_LOAD;
            idx   <= '0;
            len   <= prog_len;
            busy  <= 1'b1;
          end
        end
        S_LOAD: if (cur_dur == '0) begin
          if (last) begin
            state   <= S_DONE;
            done    <= 1'b1;
            running <= 1'b0;
          end else idx <= idx + AW'(1);
        end else begin
          state   <= S_RUN;
          cnt     <= cur_dur;
          set     <= pause ? 5'd0 : dir_onehot(cur_dir);
          running <= !pause;
        end
        S_RUN: begin
          set     <= pause ? 5'd0 : dir_onehot(cur_dir);
          running <= !pause;
          if (tick && cnt == DUR_W'(1)) begin
            set <= '0;
            if (!last && DEAD == 1) begin
              state   <= S_LOAD;
              idx     <= idx + AW'(1);
              running <= 1'b1;
            end else begin
              state <= S_GAP;
              gap   <= '0;
            end
          end else if (tick) cnt <= cnt - DUR_W'(1);
        end
        S_GAP: begin
          running <= !pause;
          if (running) begin
            if (gap == (last ? G_LAST : G_MID)) begin
              if (last) begin
                state   <= S_DONE;
                done    <= 1'b1;
                running <= 1'b0;
              end else begin
                state   <= S_LOAD;
                idx     <= idx + AW'(1);
                running <= 1'b1;
              end
            end else gap <= gap + GW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
